// File: rtl/skin_mask_bbox.sv
// Per-pixel skin classifier on a YCbCr stream. It also keeps a per-frame skin-pixel
// count and bounding box, and publishes both with a one-cycle frame_done pulse.
module skin_mask_bbox #(
  parameter int WIDTH   = 8,
  parameter int XBITS   = 10,
  parameter int YBITS   = 10,
  parameter int CNTBITS = 20,
  parameter int Y_MIN   = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic               pix_sof,
  input  logic               pix_eol,
  input  logic               pix_eof,
  input  logic [WIDTH-1:0]   y_in,
  input  logic [WIDTH-1:0]   cb_in,
  input  logic [WIDTH-1:0]   cr_in,
  input  logic [WIDTH-1:0]   cb_lo,
  input  logic [WIDTH-1:0]   cb_hi,
  input  logic [WIDTH-1:0]   cr_lo,
  input  logic [WIDTH-1:0]   cr_hi,
  output logic               mask_valid,
  output logic               mask_bit,
  output logic               mask_sof,
  output logic               mask_eol,
  output logic               mask_eof,
  output logic               frame_done,
  output logic               frame_err,
  output logic [CNTBITS-1:0] skin_count,
  output logic               bbox_valid,
  output logic [XBITS-1:0]   bbox_xmin,
  output logic [XBITS-1:0]   bbox_xmax,
  output logic [YBITS-1:0]   bbox_ymin,
  output logic [YBITS-1:0]   bbox_ymax
);

  localparam logic [WIDTH-1:0] YMIN_W = WIDTH'(Y_MIN);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q;

  logic [WIDTH-1:0]   cb_lo_q, cb_hi_q, cr_lo_q, cr_hi_q;
  logic [XBITS-1:0]   x_q, xmin_q, xmax_q;
  logic [YBITS-1:0]   y_q, ymin_q, ymax_q;
  logic               eol_q;
  logic [CNTBITS-1:0] cnt_q;

  logic               accept, skin;
  logic [WIDTH-1:0]   cbl, cbh, crl, crh;
  logic [XBITS-1:0]   cur_x, xmin_n, xmax_n;
  logic [YBITS-1:0]   cur_y, ymin_n, ymax_n;
  logic [CNTBITS-1:0] cnt_n;

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    accept = pix_valid & (pix_sof | (state_q == ACTIVE));
    // The SOF beat is classified with the live ports; later beats use the shadows.
    cbl = pix_sof ? cb_lo : cb_lo_q;
    cbh = pix_sof ? cb_hi : cb_hi_q;
    crl = pix_sof ? cr_lo : cr_lo_q;
    crh = pix_sof ? cr_hi : cr_hi_q;

    cur_x = '0;
    cur_y = '0;
    if (!pix_sof) begin
      if (eol_q) begin
        cur_y = (&y_q) ? y_q : y_q + 1'b1;
      end else begin
        cur_x = (&x_q) ? x_q : x_q + 1'b1;
        cur_y = y_q;
      end
    end

    skin = accept & (y_in >= YMIN_W) &
           (cb_in >= cbl) & (cb_in <= cbh) &
           (cr_in >= crl) & (cr_in <= crh);

    // A new frame restarts the accumulators before the SOF pixel is folded in.
    cnt_n  = pix_sof ? '0 : cnt_q;
    xmin_n = pix_sof ? '0 : xmin_q;
    xmax_n = pix_sof ? '0 : xmax_q;
    ymin_n = pix_sof ? '0 : ymin_q;
    ymax_n = pix_sof ? '0 : ymax_q;
    if (skin) begin
      if (cnt_n == '0) begin
        xmin_n = cur_x;
        xmax_n = cur_x;
        ymin_n = cur_y;
        ymax_n = cur_y;
      end else begin
        if (cur_x < xmin_n) xmin_n = cur_x;
        if (cur_x > xmax_n) xmax_n = cur_x;
        if (cur_y < ymin_n) ymin_n = cur_y;
        if (cur_y > ymax_n) ymax_n = cur_y;
      end
      cnt_n = (&cnt_n) ? cnt_n : cnt_n + 1'b1;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cb_lo_q    <= '0;
      cb_hi_q    <= '0;
      cr_lo_q    <= '0;
      cr_hi_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      eol_q      <= 1'b0;
      cnt_q      <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      mask_valid <= 1'b0;
      mask_bit   <= 1'b0;
      mask_sof   <= 1'b0;
      mask_eol   <= 1'b0;
      mask_eof   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      skin_count <= '0;
      bbox_valid <= 1'b0;
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
    end else begin
      mask_valid <= accept;
      mask_bit   <= skin;
      mask_sof   <= accept & pix_sof;
      mask_eol   <= accept & pix_eol;
      mask_eof   <= accept & pix_eof;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (accept) begin
        x_q    <= cur_x;
        y_q    <= cur_y;
        eol_q  <= pix_eol;
        cnt_q  <= cnt_n;
        xmin_q <= xmin_n;
        xmax_q <= xmax_n;
        ymin_q <= ymin_n;
        ymax_q <= ymax_n;
        if (pix_sof) begin
          cb_lo_q <= cb_lo;
          cb_hi_q <= cb_hi;
          cr_lo_q <= cr_lo;
          cr_hi_q <= cr_hi;
        end
        if (pix_eof) begin
          state_q    <= IDLE;
          frame_done <= 1'b1;
          skin_count <= cnt_n;
          bbox_valid <= (cnt_n != '0);
          bbox_xmin  <= xmin_n;
          bbox_xmax  <= xmax_n;
          bbox_ymin  <= ymin_n;
          bbox_ymax  <= ymax_n;
        end else begin
          state_q <= ACTIVE;
          // An SOF inside a frame aborts the old frame; an SOF+EOF there completes normally.
          if (pix_sof && state_q == ACTIVE) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_skin_mask_bbox.sv
// Directed bench for skin_mask_bbox. It applies hand-built frames and compares the
// mask and frame results against values computed by the bench.
module tb_skin_mask_bbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, pix_sof, pix_eol, pix_eof;
  logic [7:0]  y_in, cb_in, cr_in;
  logic [7:0]  cb_lo, cb_hi, cr_lo, cr_hi;
  logic        mask_valid, mask_bit, mask_sof, mask_eol, mask_eof;
  logic        frame_done, frame_err, bbox_valid;
  logic [19:0] skin_count;
  logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

  int n_vec = 0;
  int n_err = 0;

  int  sx[$];
  int  sy[$];
  bit  expect_err;
  int  prev_count;

  always #5 clk = ~clk;

  skin_mask_bbox dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .mask_valid(mask_valid), .mask_bit(mask_bit), .mask_sof(mask_sof),
    .mask_eol(mask_eol), .mask_eof(mask_eof),
    .frame_done(frame_done), .frame_err(frame_err), .skin_count(skin_count),
    .bbox_valid(bbox_valid), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted beat; outputs for that beat are sampled 1 ns after the edge.
  task automatic beat(input logic sof, eol, eof, input logic [7:0] y, cb, cr);
    pix_valid = 1'b1;
    pix_sof = sof; pix_eol = eol; pix_eof = eof;
    y_in = y; cb_in = cb; cr_in = cr;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0; pix_eol = 1'b0; pix_eof = 1'b0;
  endtask

  task automatic idle_cycle();
    pix_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic bit in_map(int x, int y);
    for (int i = 0; i < sx.size(); i++)
      if (sx[i] == x && sy[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // Map pixels carry in-window chroma (cb=100); others carry cb=50. The expected mask is
  // in_map && exp_en, so exp_en=0 models a frame whose sampled window excludes cb=100.
  task automatic run_frame(input int w, input int h, input bit chg, input bit exp_en, input bit gaps);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        bit first, pix;
        first = (r == 0 && c == 0);
        pix   = in_map(c, r);
        if (gaps && !first) begin
          idle_cycle();
          check("gap_mask_valid", {31'd0, mask_valid}, 32'd0);
        end
        beat(first, c == w - 1, (r == h - 1) && (c == w - 1), 8'd100, pix ? 8'd100 : 8'd50, 8'd150);
        check("mask_valid", {31'd0, mask_valid}, 32'd1);
        check($sformatf("mask_bit(%0d,%0d)", c, r), {31'd0, mask_bit}, {31'd0, pix & exp_en});
        if (first) begin
          check("mask_sof", {31'd0, mask_sof}, 32'd1);
          check("frame_err", {31'd0, frame_err}, {31'd0, expect_err});
          if (w * h > 1) begin
            check("no_early_done", {31'd0, frame_done}, 32'd0);
            check("results_held", {12'd0, skin_count}, prev_count);
          end
          if (chg) begin
            cb_lo = 8'd200;
            cb_hi = 8'd210;
          end
        end
      end
    end
  endtask

  task automatic check_results(input string tag, input int cnt, xmin, xmax, ymin, ymax);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd1);
    check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_count"}, {12'd0, skin_count}, cnt);
    check({tag, "_bvalid"}, {31'd0, bbox_valid}, {31'd0, cnt != 0});
    check({tag, "_xmin"}, {22'd0, bbox_xmin}, xmin);
    check({tag, "_xmax"}, {22'd0, bbox_xmax}, xmax);
    check({tag, "_ymin"}, {22'd0, bbox_ymin}, ymin);
    check({tag, "_ymax"}, {22'd0, bbox_ymax}, ymax);
    prev_count = cnt;
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_eof = 1'b0;
    y_in = '0; cb_in = '0; cr_in = '0;
    cb_lo = 8'd77; cb_hi = 8'd127; cr_lo = 8'd133; cr_hi = 8'd173;
    expect_err = 1'b0;
    prev_count = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mask_valid", {31'd0, mask_valid}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_count", {12'd0, skin_count}, 32'd0);
    check("rst_bbox_valid", {31'd0, bbox_valid}, 32'd0);
    rst = 1'b0;
    idle_cycle();

    // Lower window corners and upper cr edge on a one-pixel frame.
    beat(1, 1, 1, 8'd40, 8'd77, 8'd173);
    check("t1_mask_bit", {31'd0, mask_bit}, 32'd1);
    check("t1_mask_eof", {31'd0, mask_eof}, 32'd1);
    check_results("t1", 1, 0, 0, 0, 0);

    // Each boundary violation alone kills the pixel.
    beat(1, 1, 1, 8'd39, 8'd100, 8'd150);
    check("t2_y39", {31'd0, mask_bit}, 32'd0);
    check_results("t2_y39", 0, 0, 0, 0, 0);
    beat(1, 1, 1, 8'd100, 8'd128, 8'd150);
    check("t2_cb128", {31'd0, mask_bit}, 32'd0);
    beat(1, 1, 1, 8'd100, 8'd100, 8'd132);
    check("t2_cr132", {31'd0, mask_bit}, 32'd0);
    cb_lo = 8'd100; cb_hi = 8'd100;
    beat(1, 1, 1, 8'd100, 8'd100, 8'd150);
    check("t2_lo_eq_hi", {31'd0, mask_bit}, 32'd1);
    check_results("t2_eq", 1, 0, 0, 0, 0);
    cb_lo = 8'd120; cb_hi = 8'd110;
    beat(1, 1, 1, 8'd100, 8'd115, 8'd150);
    check("t2_empty_win", {31'd0, mask_bit}, 32'd0);
    check_results("t2_empty", 0, 0, 0, 0, 0);

    // Ports change to 200..210 after SOF; the rest of the frame keeps 77..127.
    cb_lo = 8'd77; cb_hi = 8'd127;
    idle_cycle();
    sx = '{0, 2}; sy = '{0, 1};
    run_frame(3, 2, 1, 1, 0);
    check_results("t4_chg", 2, 0, 2, 0, 1);
    idle_cycle();
    run_frame(3, 2, 0, 0, 0);
    check_results("t4_none", 0, 0, 0, 0, 0);
    cb_lo = 8'd77; cb_hi = 8'd127;

    idle_cycle();
    sx = '{2, 5, 3}; sy = '{1, 3, 2};
    run_frame(8, 4, 0, 1, 0);
    check_results("t3", 3, 2, 5, 1, 3);

    // Abort: two full rows plus two beats of row 2 with a skin pixel, then a new SOF.
    idle_cycle();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 2) ? 2 : 8); c++) begin
        beat(r == 0 && c == 0, c == 7, 0, 8'd100, (r == 2 && c == 1) ? 8'd100 : 8'd50, 8'd150);
      end
    end
    check("t5_pre_done", {31'd0, frame_done}, 32'd0);
    expect_err = 1'b1;
    sx = '{1}; sy = '{1};
    run_frame(2, 2, 0, 1, 0);
    expect_err = 1'b0;
    check_results("t5", 1, 1, 1, 1, 1);

    // Reset mid-frame wipes everything and raises no pulse.
    idle_cycle();
    beat(1, 0, 0, 8'd100, 8'd100, 8'd150);
    beat(0, 0, 0, 8'd100, 8'd100, 8'd150);
    rst = 1'b1;
    beat(0, 0, 1, 8'd100, 8'd100, 8'd150);
    rst = 1'b0;
    check("t6_rst_mask_valid", {31'd0, mask_valid}, 32'd0);
    check("t6_rst_mask_bit", {31'd0, mask_bit}, 32'd0);
    check("t6_rst_done", {31'd0, frame_done}, 32'd0);
    check("t6_rst_err", {31'd0, frame_err}, 32'd0);
    check("t6_rst_count", {12'd0, skin_count}, 32'd0);
    check("t6_rst_bvalid", {31'd0, bbox_valid}, 32'd0);
    check("t6_rst_xmax", {22'd0, bbox_xmax}, 32'd0);
    beat(0, 0, 0, 8'd100, 8'd100, 8'd150);
    check("t6_nosof_valid", {31'd0, mask_valid}, 32'd0);
    beat(0, 1, 1, 8'd100, 8'd100, 8'd150);
    check("t6_nosof_done", {31'd0, frame_done}, 32'd0);
    prev_count = 0;
    sx = '{2}; sy = '{0};
    run_frame(4, 1, 0, 1, 1);
    check_results("t6_gaps", 1, 2, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
